// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch front end.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int INSTR_W    = 32;

  localparam int unsigned INSTR_BYTES = 4;
  // Low PC bits that are forced to zero on every fetch address.
  localparam int unsigned PC_ALIGN_MASK = INSTR_BYTES - 1;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [INSTR_W-1:0]    instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a registered head entry, a clear input and an occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic             do_push;
  logic             do_pop;
  entry_t           head_next;
  logic [CNT_W-1:0] count_next;

  assign do_pop     = pop && (count != '0);
  assign do_push    = push && (count != CNT_W'(DEPTH));
  assign rd_ptr_inc = rd_ptr + 1'b1;

  // The head register always holds the entry at rd_ptr, so it looks ahead one slot on a pop.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    head_next  = head;
    count_next = count;
    if (clear) begin
      head_next  = '0;
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_pop) begin
        if (count > CNT_W'(1)) head_next = mem[rd_ptr_inc];
        else if (do_push)      head_next = push_data;
      end else if (do_push && (count == '0)) begin
        head_next = push_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      count <= count_next;
      head  <= head_next;
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr_inc;
      end
    end
  end

  // NOTE: storage is not reset; count and pointers alone decide which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: issues sequential imem requests, queues returned
// instructions with their PCs, and discards stale fetches after a redirect.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              QDEPTH          = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  localparam int             QCNT_W          = $clog2(QDEPTH + 1),
  localparam int             OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [XLEN-1:0]   id_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [QCNT_W-1:0] q_count,
  output logic [OUT_W-1:0]  outstanding
);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_CLR = ~XLEN'(PC_ALIGN_MASK);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  rsp_pc;
  logic [OUT_W-1:0] drop_cnt;
  logic [XLEN-1:0]  redirect_pc_aligned;
  logic             req_fire;
  logic             rsp_dec;
  logic             rsp_push;
  logic             deq;
  entry_t           push_entry;
  entry_t           head;

  assign redirect_pc_aligned = redirect_pc & ALIGN_CLR;

  // Queue space is reserved at issue: in-flight requests count against free entries,
  // so a returning response can never find the queue full.
  assign imem_req_valid = rst && !redirect_valid
                       && ((32'(q_count) + 32'(outstanding)) < 32'(QDEPTH))
                       && (32'(outstanding) < 32'(MAX_OUTSTANDING));
  assign imem_req_addr  = fetch_pc;

  assign req_fire   = imem_req_valid && imem_req_ready;
  assign rsp_dec    = imem_rsp_valid && (outstanding != '0);
  assign rsp_push   = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign deq        = id_valid && id_ready && !redirect_valid;
  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OUT_W'(req_fire) - OUT_W'(rsp_dec);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc_aligned;
        rsp_pc   <= redirect_pc_aligned;
        // Recomputed from the live count so back-to-back redirects never double-count.
        drop_cnt <= outstanding - OUT_W'(rsp_dec);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (rsp_push) rsp_pc   <= rsp_pc + PC_STEP;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (rsp_push),
    .push_data (push_entry),
    .pop       (deq),
    .head      (head),
    .count     (q_count)
  );

  assign id_valid = (q_count != '0);
  assign id_instr = head.instr;
  assign id_pc    = head.pc;

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the 5-stage RV32 pipeline. It replaces the bare PC register plus combinational instruction-memory lookup.
- Issues PC-sequential requests to an instruction memory with variable, in-order response latency.
- Buffers returned instructions with their PCs in a QDEPTH-entry queue and presents them to decode over a valid/ready handshake.
- On a redirect (taken branch, jump, flush) it discards queued and in-flight fetches.

Parameters:
- XLEN, 32, PC/address width.
- QDEPTH, 4, fetch queue entries; power of 2, at least 2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests; at least 1.
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  instruction returned this cycle, in request order.
- imem_rsp_data  in  32  returned instruction word.
- id_valid  out  1  queue head valid to decode.
- id_ready  in  1  decode consumes head (low = stall/retain).
- id_instr  out  32  head instruction.
- id_pc  out  XLEN  PC of head instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored, treated as 0.
- q_count  out  $clog2(QDEPTH+1)  occupied queue entries.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight requests, including doomed ones.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - queue empty, q_count=0, outstanding=0, drop_cnt=0.
  - id_valid=0, id_instr=0, id_pc=0.
  - imem_req_valid=0 while rst=0.
- Request issue:
  - imem_req_valid = !redirect_valid && (q_count+outstanding) < QDEPTH && outstanding < MAX_OUTSTANDING.
  - imem_req_addr=fetch_pc.
  - The request fires on valid&&ready; then fetch_pc += 4 and outstanding += 1. The address wraps modulo 2^XLEN.
  - req_valid may drop without acceptance only in a redirect cycle. The memory must not depend on valid persistence.
- Response:
  - Each imem_rsp_valid decrements outstanding. A request fire and a response in the same cycle leave outstanding unchanged.
  - If drop_cnt>0: the response is discarded and drop_cnt -= 1.
  - Otherwise {rsp_pc, imem_rsp_data} is pushed and rsp_pc += 4.
  - A response with outstanding=0 is illegal and is a bench assertion.
- Queue space is reserved at issue, so a push never finds the queue full. Overflow is a bench assertion.
- Dequeue:
  - id_valid = (q_count != 0); id_instr/id_pc are the head entry, registered.
  - Pop on id_valid&&id_ready.
  - Simultaneous push and pop leaves q_count unchanged.
  - No bypass: a response in cycle N is visible on id_* in cycle N+1 at the earliest.
- Redirect (redirect_valid=1, priority over everything):
  - Queue cleared, so q_count=0 next cycle and id_valid=0 next cycle. No pop takes effect.
  - fetch_pc, rsp_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - Any response this cycle is discarded.
  - drop_cnt <= outstanding - imem_rsp_valid.
  - No request is issued this cycle. Fetching resumes the following cycle at the new PC.
- Back-to-back redirects: the second overrides the first.
  - drop_cnt is recomputed from the current outstanding value, so doomed responses are never double-counted.
- Stall: with id_ready=0 the head holds stable. Issue continues until q_count+outstanding=QDEPTH.
- Reset mid-operation: all state returns to reset values immediately. In-flight memory responses after reset release are the memory's responsibility: it is reset on the same rst.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t {pc[XLEN-1:0], instr[31:0]}.
  - constants INSTR_BYTES=4 and PC_ALIGN_MASK.
- Sub-module fetch_fifo: synchronous FIFO parametrised by width and DEPTH.
  - push/pop/clear ports, registered head, count output.
  - Holds fetch_entry_t.
- The top holds the PC, rsp_pc, outstanding and drop counters, and the issue logic.

Test Plan:
- Reset release, imem ready and 1-cycle latency, id_ready=1 → addresses 0,4,8,…; id_pc 0,4,8 in order; first id_valid 2 cycles after first request fire.
- id_ready=0 with QDEPTH=4, MAX_OUTSTANDING=2 → exactly 4 requests issued; q_count=4; imem_req_valid=0; head id_pc=0 stable; release id_ready → issue resumes at 0x10.
- Memory latency 3, two requests outstanding (0x8, 0xC), redirect to 0x100 → both late responses discarded; next id_pc=0x100; drop_cnt returns to 0.
- Redirect and response in the same cycle with outstanding=1 → response dropped; drop_cnt=0; next accepted request addr=0x200 (redirect_pc=0x202 aligned down).
- Redirects in two consecutive cycles (0x40 then 0x80) → no instruction from 0x40 ever reaches id_*; first id_pc=0x80.
- rst asserted mid-stream with q_count=3 → id_valid=0 and q_count=0 immediately; after release first request addr=RESET_PC.
